// File: rtl/f1_reaction_timer_if.sv
`default_nettype none
// ============================================================================
//  Module   : f1_reaction_timer_if
//  Purpose  : Bundles the light pattern, driver button and measurement results
//             exchanged between the light sequencer/driver side and the
//             reaction timer.
//  Ports    : lights       - 8-bit light pattern from the f1_lights sequence
//             btn          - driver button level, synchronous to clk
//             react_ms     - last measured reaction time in ms
//             result_valid - one-cycle pulse when react_ms updates
//             false_start  - level, button pressed before lights out
//             timeout      - level, no press within the time limit
//             busy         - high while a start sequence/measurement is live
//  Revision : 1.0 - initial release
// ============================================================================
interface f1_reaction_timer_if;
    logic [7:0]  lights;
    logic        btn;
    logic [15:0] react_ms;
    logic        result_valid;
    logic        false_start;
    logic        timeout;
    logic        busy;

    // Driver / sequencer side
    modport master (
        output lights,
        output btn,
        input  react_ms,
        input  result_valid,
        input  false_start,
        input  timeout,
        input  busy
    );

    // Reaction timer side
    modport slave (
        input  lights,
        input  btn,
        output react_ms,
        output result_valid,
        output false_start,
        output timeout,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/f1_reaction_timer.sv
`default_nettype none
// ============================================================================
//  Module   : f1_reaction_timer
//  Purpose  : Measures the driver's reaction time from "lights out" (pattern
//             goes from all-on to all-off) to the button press, in
//             milliseconds, and flags jump starts and timeouts.
//  Ports    : clk  - single clock, all state on its rising edge
//             rst  - synchronous, active-high reset
//             bus  - f1_reaction_timer_if.slave (lights, btn in; react_ms,
//                    result_valid, false_start, timeout, busy out)
//  Params   : CYC_PER_MS - clk cycles per millisecond of measured time
//             MAX_MS     - timeout limit in ms, 1..65535
//  Revision : 1.0 - initial release
// ============================================================================
module f1_reaction_timer #(
    parameter int CYC_PER_MS = 1000,
    parameter int MAX_MS     = 999
) (
    input  wire logic          clk,
    input  wire logic          rst,
    f1_reaction_timer_if.slave bus
);

    localparam int PW = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam logic [PW-1:0] C_PRESC_LAST = PW'(CYC_PER_MS - 1);
    localparam logic [15:0]   C_MAX_MS     = 16'(MAX_MS);

    if (MAX_MS < 1 || MAX_MS > 65535) begin : g_bad_max_ms
        $error("f1_reaction_timer: MAX_MS must be within 1..65535");
    end
    if (CYC_PER_MS < 1) begin : g_bad_cyc_per_ms
        $error("f1_reaction_timer: CYC_PER_MS must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_ALL_ON = 3'd2,
        ST_TIMING = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    state_t         r_state;
    logic           r_btn_q;
    logic [PW-1:0]  r_presc;
    logic [15:0]    r_ms_cnt;
    logic [15:0]    r_react_ms;
    logic           r_result_valid;
    logic           r_false_start;
    logic           r_timeout;
    logic           r_busy;

    logic           w_press;
    logic           w_presc_wrap;

    // Rising edge of the button; r_btn_q resets to 1 so a button already held
    // when reset releases is not taken as a press.
    assign w_press      = bus.btn & ~r_btn_q;
    assign w_presc_wrap = (r_presc == C_PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_btn_q        <= 1'b1;
            r_presc        <= '0;
            r_ms_cnt       <= '0;
            r_react_ms     <= '0;
            r_result_valid <= 1'b0;
            r_false_start  <= 1'b0;
            r_timeout      <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_btn_q        <= bus.btn;
            r_result_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Presses are ignored here; only a new sequence matters.
                    if (bus.lights != 8'h00) begin
                        r_state       <= ST_ARMED;
                        r_busy        <= 1'b1;
                        r_false_start <= 1'b0;
                        r_timeout     <= 1'b0;
                    end
                end

                ST_ARMED: begin
                    if (w_press) begin
                        r_state       <= ST_FAULT;
                        r_false_start <= 1'b1;
                        r_busy        <= 1'b0;
                    end else if (bus.lights == 8'hFF) begin
                        r_state <= ST_ALL_ON;
                    end else if (bus.lights == 8'h00) begin
                        // Sequence aborted before all lights came on.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_ALL_ON: begin
                    // A press on the very lights-out edge is still a jump start.
                    if (w_press) begin
                        r_state       <= ST_FAULT;
                        r_false_start <= 1'b1;
                        r_busy        <= 1'b0;
                    end else if (bus.lights == 8'h00) begin
                        r_state  <= ST_TIMING;
                        r_presc  <= '0;
                        r_ms_cnt <= '0;
                    end
                end

                ST_TIMING: begin
                    if (w_press) begin
                        // Report the completed milliseconds seen so far; a
                        // same-cycle wrap is deliberately not counted.
                        r_state        <= ST_DONE;
                        r_react_ms     <= r_ms_cnt;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                    end else if (w_presc_wrap) begin
                        if (r_ms_cnt == C_MAX_MS) begin
                            // The millisecond after MAX_MS would complete:
                            // stop here so ms_cnt never passes MAX_MS.
                            r_state        <= ST_DONE;
                            r_react_ms     <= C_MAX_MS;
                            r_timeout      <= 1'b1;
                            r_result_valid <= 1'b1;
                            r_busy         <= 1'b0;
                        end else begin
                            r_ms_cnt <= r_ms_cnt + 16'd1;
                            r_presc  <= '0;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                ST_FAULT: begin
                    // false_start is held until the next sequence starts.
                    if (bus.lights == 8'h00) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.react_ms     = r_react_ms;
    assign bus.result_valid = r_result_valid;
    assign bus.false_start  = r_false_start;
    assign bus.timeout      = r_timeout;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_f1_reaction_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_f1_reaction_timer
//  Purpose  : Self-checking bench for f1_reaction_timer (CYC_PER_MS=4,
//             MAX_MS=10): a per-cycle vector table, hand-written corner
//             sequences and randomized trials against an outcome model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_f1_reaction_timer;

    localparam int CYC     = 4;
    localparam int MAXMS   = 10;
    // Edge (counted from the lights-out edge E0) at which a timeout is declared
    localparam int TO_EDGE = (MAXMS + 1) * CYC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    f1_reaction_timer_if ifc ();

    f1_reaction_timer #(
        .CYC_PER_MS (CYC),
        .MAX_MS     (MAXMS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rv_cnt = 0;

    always @(negedge clk) begin
        if (ifc.result_valid === 1'b1) rv_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] lights;
        logic       btn;
        logic       rv;
        logic       fs;
        logic       to;
        logic       busy;
        int         react;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] l, input logic b, input logic rv,
                                input logic fs, input logic to, input logic bz,
                                input int r);
        vec_t v;
        v.lights = l; v.btn = b; v.rv = rv; v.fs = fs; v.to = to; v.busy = bz; v.react = r;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int rv, input int fs, input int to,
                           input int bz, input int react);
        chk({tag, ".result_valid"}, 32'(ifc.result_valid), 32'(rv));
        chk({tag, ".false_start"},  32'(ifc.false_start),  32'(fs));
        chk({tag, ".timeout"},      32'(ifc.timeout),      32'(to));
        chk({tag, ".busy"},         32'(ifc.busy),         32'(bz));
        chk({tag, ".react_ms"},     32'(ifc.react_ms),     32'(react));
    endtask

    // Walk the start lights 01,03,...,FF, each held for 'hold' cycles.
    task automatic arm_lights(input int hold);
        logic [7:0] p;
        p = 8'h01;
        for (int s = 0; s < 8; s++) begin
            ifc.lights = p;
            repeat (hold) step();
            p = {p[6:0], 1'b1};
        end
    endtask

    // Lights out, then press on edge E_d (d<1 or beyond the window: no press).
    task automatic run_out(input int d, output int seen, output int react,
                           output int to, output int pulses);
        int start;
        start = rv_cnt;
        seen  = -1;
        react = -1;
        to    = -1;
        ifc.lights = 8'h00;
        step();
        for (int i = 1; i <= TO_EDGE + 6; i++) begin
            ifc.btn = (i == d);
            step();
            if (ifc.result_valid === 1'b1 && seen < 0) begin
                seen  = i;
                react = int'(ifc.react_ms);
                to    = int'(ifc.timeout);
            end
        end
        ifc.btn = 1'b0;
        step();
        pulses = rv_cnt - start;
    endtask

    // Outcome model: whole milliseconds elapsed before the press edge, or a
    // timeout once MAX_MS+1 milliseconds would have elapsed.
    task automatic model(input int d, output int seen, output int react, output int to);
        if (d >= 1 && d <= TO_EDGE) begin
            seen  = d;
            react = (d - 1) / CYC;
            to    = 0;
        end else begin
            seen  = TO_EDGE;
            react = MAXMS;
            to    = 1;
        end
    endtask

    task automatic timed_trial(input string tag, input int hold, input int d);
        int s, r, t, p, es, er, et;
        arm_lights(hold);
        chk({tag, ".busy_armed"}, 32'(ifc.busy), 32'd1);
        run_out(d, s, r, t, p);
        model(d, es, er, et);
        chk({tag, ".cycle"},   32'(s), 32'(es));
        chk({tag, ".react"},   32'(r), 32'(er));
        chk({tag, ".timeout"}, 32'(t), 32'(et));
        chk({tag, ".pulses"},  32'(p), 32'd1);
        chk({tag, ".fs"},      32'(ifc.false_start), 32'd0);
    endtask

    task automatic jump_trial(input string tag, input int hold, input int stg);
        logic [7:0] pat;
        int start;
        start = rv_cnt;
        pat   = 8'h01;
        for (int s = 0; s < 8; s++) begin
            ifc.lights = pat;
            ifc.btn    = (s >= stg);
            repeat (hold) step();
            pat = {pat[6:0], 1'b1};
        end
        chk({tag, ".fs"},   32'(ifc.false_start), 32'd1);
        chk({tag, ".busy"}, 32'(ifc.busy),        32'd0);
        ifc.lights = 8'h00;
        repeat (3) step();
        ifc.btn = 1'b0;
        step();
        chk({tag, ".fs_hold"}, 32'(ifc.false_start), 32'd1);
        chk({tag, ".no_rv"},   32'(rv_cnt - start),  32'd0);
    endtask

    initial begin
        int s, r, t, p, start, mode, hold, d;

        ifc.lights = 8'h00;
        ifc.btn    = 1'b0;
        rst        = 1'b1;
        repeat (3) step();
        chk_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // ---- per-cycle vector table --------------------------------------
        //               lights btn  rv  fs  to  busy react
        tbl.push_back(mk(8'h00, 0,   0,  0,  0,  0,   0)); // idle
        tbl.push_back(mk(8'h01, 0,   0,  0,  0,  1,   0)); // armed
        tbl.push_back(mk(8'h00, 0,   0,  0,  0,  0,   0)); // aborted
        tbl.push_back(mk(8'h01, 0,   0,  0,  0,  1,   0));
        tbl.push_back(mk(8'h03, 1,   0,  1,  0,  0,   0)); // jump start
        tbl.push_back(mk(8'h07, 1,   0,  1,  0,  0,   0));
        tbl.push_back(mk(8'h00, 0,   0,  1,  0,  0,   0)); // fault -> idle
        tbl.push_back(mk(8'h00, 1,   0,  1,  0,  0,   0)); // press in idle ignored
        tbl.push_back(mk(8'h01, 1,   0,  0,  0,  1,   0)); // flags clear, held btn
        tbl.push_back(mk(8'hFF, 1,   0,  0,  0,  1,   0)); // all on
        tbl.push_back(mk(8'hFF, 0,   0,  0,  0,  1,   0));
        tbl.push_back(mk(8'h00, 0,   0,  0,  0,  1,   0)); // lights out E0
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(8'h00, 0, 0, 0, 0, 1, 0));      // E1..E5
        tbl.push_back(mk(8'h00, 1,   1,  0,  0,  0,   1)); // press at E6
        tbl.push_back(mk(8'h00, 0,   0,  0,  0,  0,   1)); // done -> idle
        tbl.push_back(mk(8'h01, 0,   0,  0,  0,  1,   1));
        tbl.push_back(mk(8'hFF, 0,   0,  0,  0,  1,   1));
        tbl.push_back(mk(8'h00, 1,   0,  1,  0,  0,   1)); // press beats lights out
        tbl.push_back(mk(8'h00, 0,   0,  1,  0,  0,   1));

        for (int i = 0; i < tbl.size(); i++) begin
            ifc.lights = tbl[i].lights;
            ifc.btn    = tbl[i].btn;
            step();
            chk_out($sformatf("vec%0d", i), int'(tbl[i].rv), int'(tbl[i].fs),
                    int'(tbl[i].to), int'(tbl[i].busy), tbl[i].react);
        end
        ifc.btn = 1'b0;
        step();

        // ---- normal run: press 13 cycles after lights out -> 3 ms --------
        timed_trial("normal", 1, 13);
        // ---- no press: timeout at edge 44 with 10 ms ---------------------
        timed_trial("timeout", 2, 0);
        // ---- press on the timeout edge: press wins -----------------------
        timed_trial("coincide", 1, TO_EDGE);

        // ---- randomized trials -------------------------------------------
        for (int n = 0; n < 16; n++) begin
            mode = int'($urandom_range(0, 3));
            hold = int'($urandom_range(1, 3));
            case (mode)
                0:       jump_trial($sformatf("rnd%0d_jump", n), hold, int'($urandom_range(1, 7)));
                1:       timed_trial($sformatf("rnd%0d", n), hold, int'($urandom_range(1, TO_EDGE)));
                2:       timed_trial($sformatf("rnd%0d", n), hold, int'($urandom_range(TO_EDGE - 2, TO_EDGE + 3)));
                default: timed_trial($sformatf("rnd%0d", n), hold, int'($urandom_range(1, 8)));
            endcase
        end

        // ---- button held across reset and the whole start sequence -------
        ifc.btn = 1'b1;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        ifc.lights = 8'h00;
        step();
        start = rv_cnt;
        arm_lights(1);
        chk("held.fs",   32'(ifc.false_start), 32'd0);
        chk("held.busy", 32'(ifc.busy),        32'd1);
        ifc.lights = 8'h00;
        step();
        repeat (8) step();
        chk("held.no_rv", 32'(rv_cnt - start), 32'd0);
        ifc.btn = 1'b0;
        step();                                  // E9
        ifc.btn = 1'b1;
        step();                                  // E10 press
        chk("held.rv",    32'(ifc.result_valid), 32'd1);
        chk("held.react", 32'(ifc.react_ms),     32'((10 - 1) / CYC));
        ifc.btn = 1'b0;
        step();
        chk("held.pulses", 32'(rv_cnt - start), 32'd1);

        // ---- reset in the middle of timing (ms_cnt = 5) ------------------
        arm_lights(1);
        ifc.lights = 8'h00;
        step();                                  // E0
        repeat (22) step();                      // E22: 5 ms elapsed
        start = rv_cnt;
        rst   = 1'b1;
        step();
        chk_out("rst_mid", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        ifc.btn = 1'b1;                          // would end a live measurement
        step();
        ifc.btn = 1'b0;
        repeat (50) step();
        chk("rst_mid.no_rv", 32'(rv_cnt - start), 32'd0);
        ifc.lights = 8'h01;
        step();
        chk("rst_mid.rearm", 32'(ifc.busy), 32'd1);
        ifc.lights = 8'h00;
        step();
        chk("rst_mid.abort", 32'(ifc.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/f1_reaction_timer.md
F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

Interface
REQ-001 Parameter CYC_PER_MS, default 1000: clk cycles per millisecond of measured time.
REQ-002 Parameter MAX_MS, default 999: timeout limit in ms; the block SHALL require 1 <= MAX_MS <= 65535.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 lights  input  8  light pattern driven by the f1_lights sequence (its data_out).
REQ-006 btn  input  1  driver button level, already synchronous to clk.
REQ-007 react_ms  output  16  last measured reaction time in ms.
REQ-008 result_valid  output  1  one-cycle pulse when react_ms is updated.
REQ-009 false_start  output  1  level: button pressed before lights out.
REQ-010 timeout  output  1  level: no press within MAX_MS.
REQ-011 busy  output  1  high in ARMED, ALL_ON and TIMING.

Function
REQ-012 The block SHALL register btn into btn_q each cycle, where press = btn & ~btn_q; a held button SHALL generate only one press.
REQ-013 The FSM SHALL have the states IDLE, ARMED, ALL_ON, TIMING, DONE and FAULT.
REQ-014 IDLE -> ARMED when lights != 8'h00, and entry SHALL clear false_start and timeout; react_ms SHALL be retained.
REQ-015 ARMED -> ALL_ON when lights == 8'hFF; ARMED -> IDLE when lights == 8'h00 (aborted sequence).
REQ-016 ALL_ON -> TIMING when lights == 8'h00, and on that edge prescaler and ms_cnt SHALL be cleared to 0.
REQ-017 A press in ARMED or ALL_ON -> FAULT with false_start <= 1, and press SHALL take priority over the lights transitions in the same cycle.
REQ-018 TIMING: the prescaler SHALL count 0..CYC_PER_MS-1 and wrap; on wrap, ms_cnt SHALL increment by 1.
REQ-019 A press in TIMING -> DONE, react_ms <= ms_cnt (current value, before any same-cycle increment).
REQ-020 In TIMING, when ms_cnt == MAX_MS with no press -> DONE, react_ms <= MAX_MS, timeout <= 1; if press and timeout coincide, the press SHALL win (timeout stays 0).
REQ-021 result_valid SHALL be 1 for exactly the single cycle the FSM is in DONE; DONE -> IDLE unconditionally.
REQ-022 FAULT -> IDLE when lights == 8'h00, and false_start SHALL stay 1 until the next IDLE -> ARMED.
REQ-023 In IDLE, DONE and FAULT, presses SHALL be ignored (no state or output change).
REQ-024 Press-to-result latency SHALL be 1 cycle: press sampled at edge n gives result_valid high for the cycle after edge n.
REQ-025 ms_cnt SHALL be 16 bits and SHALL never exceed MAX_MS.

Reset
REQ-026 On rst = 1 at a clock edge, the block SHALL set state=IDLE, react_ms=0, result_valid=0, false_start=0, timeout=0, busy=0, prescaler=0, ms_cnt=0 and btn_q=1.
REQ-027 Reset SHALL override every transition, including mid-TIMING, and no result_valid SHALL be emitted.

Verification (bench uses CYC_PER_MS=4, MAX_MS=10)
REQ-028 Normal: lights 01->03->...->FF->00, press 13 cycles after 00 -> react_ms=3, result_valid one cycle, false_start=0, timeout=0.
REQ-029 Jump start: press while lights=8'h1F -> false_start=1, busy=0, no result_valid; lights 00 then 01 -> false_start clears, busy=1.
REQ-030 Timeout: lights FF->00, btn held low -> after 44 cycles react_ms=10, timeout=1, single result_valid.
REQ-031 Press and timeout in the same cycle -> react_ms=10, timeout=0, result_valid=1.
REQ-032 btn held high across IDLE->TIMING (pressed before reset, btn_q=1) -> no false start and no result until btn is released and pressed again.
REQ-033 rst asserted mid-TIMING with ms_cnt=5 -> next cycle all outputs 0, state IDLE, and no result_valid at any point.
